// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_if
//  Purpose  : Bundles the pipeline hazard/event inputs and the stage-register
//             enable/flush outputs of the pipeline sequencer.
//  Signals  : id_rs1_i/id_rs2_i/ex_rd_i   register indices for load-use check
//             ex_is_load_i/ex_busy_i/ex_redirect_i  EX stage events
//             mem_req_i/mem_ready_i        data-memory handshake
//             trap_i                       trap committed at WB
//             pc_en_o, *_en_o, *_flush_o   PC and stage register controls
//             trap_take_o, mem_timeout_o, stall_cnt_o  status outputs
//  Modports : master - the sequencer (events in, controls out)
//             slave  - the pipeline datapath (events out, controls in)
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1_i;
   logic [4:0]       id_rs2_i;
   logic [4:0]       ex_rd_i;
   logic             ex_is_load_i;
   logic             ex_busy_i;
   logic             ex_redirect_i;
   logic             mem_req_i;
   logic             mem_ready_i;
   logic             trap_i;
   logic             pc_en_o;
   logic             if_id_en_o;
   logic             id_ex_en_o;
   logic             ex_mem_en_o;
   logic             mem_wb_en_o;
   logic             if_id_flush_o;
   logic             id_ex_flush_o;
   logic             ex_mem_flush_o;
   logic             mem_wb_flush_o;
   logic             trap_take_o;
   logic             mem_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      input  id_rs1_i, id_rs2_i, ex_rd_i, ex_is_load_i, ex_busy_i,
             ex_redirect_i, mem_req_i, mem_ready_i, trap_i,
      output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
             trap_take_o, mem_timeout_o, stall_cnt_o
   );

   modport slave (
      output id_rs1_i, id_rs2_i, ex_rd_i, ex_is_load_i, ex_busy_i,
             ex_redirect_i, mem_req_i, mem_ready_i, trap_i,
      input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
             trap_take_o, mem_timeout_o, stall_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Central stall/bubble/flush sequencer of the 5-stage pipeline.
//             Resolves load-use, multi-cycle EX, data-memory wait, branch
//             redirect and trap events into one consistent control pattern.
//  Ports    : clk_i   clock
//             rst_ni  asynchronous active-low reset
//             bus     pipe_ctrl_if.master (events in, stage controls out)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
   parameter int BOOT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  wire logic     clk_i,
   input  wire logic     rst_ni,
   pipe_ctrl_if.master   bus
);

   typedef enum logic [1:0] {
      BOOT       = 2'd0,
      RUN        = 2'd1,
      MEM_WAIT   = 2'd2,
      TRAP_DRAIN = 2'd3
   } state_t;

   localparam int              WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [7:0]      BOOT_LAST  = 8'(BOOT_CYCLES - 1);

   state_t            state;
   logic [7:0]        boot_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CNT_W-1:0]  stall_cnt;

   logic memstall, loaduse, waiting, boot;
   logic do_trap, do_mem, do_busy, do_redir, do_lu;
   logic pc_en;

   assign memstall = bus.mem_req_i & ~bus.mem_ready_i;
   assign loaduse  = bus.ex_is_load_i & (bus.ex_rd_i != 5'd0) &
                     ((bus.id_rs1_i == bus.ex_rd_i) | (bus.id_rs2_i == bus.ex_rd_i));
   assign boot     = (state == BOOT);

   // In TRAP_DRAIN the bus access must finish, so only mem_ready_i ends the wait.
   assign waiting  = (state == TRAP_DRAIN) ? ~bus.mem_ready_i : (~boot & memstall);

   // Select exactly one action per cycle; the later terms are masked by the earlier.
   always_comb begin
      do_trap  = 1'b0;
      do_mem   = 1'b0;
      do_busy  = 1'b0;
      do_redir = 1'b0;
      do_lu    = 1'b0;
      case (state)
         BOOT: ;
         TRAP_DRAIN: begin
            if (bus.mem_ready_i) do_trap = 1'b1;
            else                 do_mem  = 1'b1;
         end
         default: begin
            if (bus.trap_i & ~memstall)  do_trap  = 1'b1;
            else if (memstall)           do_mem   = 1'b1;
            else if (bus.ex_busy_i)      do_busy  = 1'b1;
            else if (bus.ex_redirect_i)  do_redir = 1'b1;
            else if (loaduse)            do_lu    = 1'b1;
         end
      endcase
   end

   // A held register never sees its flush: each flush term excludes the holds.
   assign pc_en              = ~(boot | do_mem | do_busy | do_lu);
   assign bus.pc_en_o        = pc_en;
   assign bus.if_id_en_o     = ~(boot | do_mem | do_busy | do_lu);
   assign bus.id_ex_en_o     = ~(boot | do_mem | do_busy);
   assign bus.ex_mem_en_o    = ~(boot | do_mem);
   assign bus.mem_wb_en_o    = ~boot;
   assign bus.if_id_flush_o  = boot | do_trap | do_redir;
   assign bus.id_ex_flush_o  = boot | do_trap | do_redir | do_lu;
   assign bus.ex_mem_flush_o = boot | do_trap | do_busy;
   assign bus.mem_wb_flush_o = boot | do_trap | do_mem;
   assign bus.trap_take_o    = do_trap;
   assign bus.mem_timeout_o  = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TIMEOUT_M1);
   assign bus.stall_cnt_o    = stall_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= BOOT;
         boot_cnt  <= '0;
         wait_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         case (state)
            BOOT: begin
               boot_cnt <= boot_cnt + 8'd1;
               if (boot_cnt == BOOT_LAST) state <= RUN;
            end
            RUN, MEM_WAIT: begin
               if (memstall) state <= bus.trap_i ? TRAP_DRAIN : MEM_WAIT;
               else          state <= RUN;
            end
            TRAP_DRAIN: begin
               if (bus.mem_ready_i) state <= RUN;
            end
            default: state <= BOOT;
         endcase

         if (!boot) begin
            if (!pc_en) stall_cnt <= stall_cnt + 1'b1;
            // Saturates at the timeout value so the pulse fires only once.
            if (waiting) begin
               if (wait_cnt != TIMEOUT_V) wait_cnt <= wait_cnt + 1'b1;
            end else begin
               wait_cnt <= '0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the 5-stage core pipeline.
- Drives the enable/flush pair of every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC enable.
- Resolves load-use, multi-cycle EX, data-memory wait, branch redirect and trap events into one consistent stall/bubble/flush pattern each cycle.
- Stage registers treat flush as synchronous and dominant over enable. This block therefore never asserts flush on a register it intends to hold.

Parameters:
BOOT_CYCLES, 4, cycles after reset release during which the pipeline is held flushed (range 1..255)
MEM_TIMEOUT, 255, consecutive MEM-wait cycles before mem_timeout_o pulses; 0 disables the check
CNT_W, 32, width of the stall performance counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
id_rs1_i  in  5  rs1 index of the instruction in ID
id_rs2_i  in  5  rs2 index of the instruction in ID
ex_rd_i  in  5  rd of the instruction in EX
ex_is_load_i  in  1  instruction in EX is a load
ex_busy_i  in  1  multi-cycle EX unit not finished
ex_redirect_i  in  1  taken branch/jump resolved in EX
mem_req_i  in  1  MEM stage has an outstanding data access
mem_ready_i  in  1  data memory completes the access this cycle
trap_i  in  1  trap/exception committed at WB
pc_en_o  out  1  PC register update enable
if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  stage register enables
if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  stage register flushes
trap_take_o  out  1  PC loads the trap vector this cycle
mem_timeout_o  out  1  one-cycle pulse on MEM wait timeout
stall_cnt_o  out  CNT_W  cycles with pc_en_o=0, excluding BOOT

Behaviour:
- Reset (asynchronous, active-low; clock clk_i):
  - state=BOOT, boot counter=0, wait counter=0, stall_cnt_o=0.
  - Outputs during reset: all flushes=1, all enables=0, pc_en_o=0, trap_take_o=0, mem_timeout_o=0.
- Derived terms:
  - memstall = mem_req_i & ~mem_ready_i
  - loaduse = ex_is_load_i & (ex_rd_i!=0) & ((id_rs1_i==ex_rd_i)|(id_rs2_i==ex_rd_i))
- States: BOOT, RUN, MEM_WAIT, TRAP_DRAIN.
- BOOT:
  - All flushes=1, all enables=0, pc_en_o=0.
  - Boot counter increments each cycle; after BOOT_CYCLES cycles -> RUN.
  - All event inputs are ignored.
- RUN/MEM_WAIT output priority (first match wins; unlisted enables=1, unlisted flushes=0):
  1. trap_i & ~memstall: flush IF/ID, ID/EX, EX/MEM, MEM/WB; pc_en_o=1; trap_take_o=1.
  2. memstall: pc_en_o, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_flush=1 (bubble into WB).
  3. ex_busy_i: pc_en_o, if_id_en, id_ex_en = 0; ex_mem_flush=1.
  4. ex_redirect_i: flush IF/ID and ID/EX; pc_en_o=1.
  5. loaduse: pc_en_o=0, if_id_en=0; id_ex_flush=1.
  6. Otherwise: all enables=1.
- Transitions:
  - RUN->MEM_WAIT on memstall.
  - MEM_WAIT->RUN on mem_ready_i (that cycle's outputs follow the priority list with memstall=0).
  - trap_i while memstall (RUN or MEM_WAIT) -> TRAP_DRAIN.
- TRAP_DRAIN:
  - The bus access cannot be aborted; hold the pipeline with priority-2 outputs until mem_ready_i.
  - Trap is latched; trap_i may deassert.
  - In the mem_ready_i cycle: apply priority-1 outputs, then -> RUN.
  - ex_redirect_i and loaduse are ignored in TRAP_DRAIN.
- Wait counter:
  - Counts consecutive memstall cycles in MEM_WAIT/TRAP_DRAIN; cleared on leaving.
  - mem_timeout_o pulses once when the count reaches MEM_TIMEOUT; the counter then saturates and waiting continues.
- stall_cnt_o: increments (wrapping modulo 2^CNT_W) every non-BOOT cycle with pc_en_o=0.
- Outputs are combinational from state and inputs; no added latency.
- Reset asserted mid-operation returns to BOOT from any state; a latched trap is discarded.

Test Plan:
- Reset, BOOT_CYCLES=4 -> flushes=1 for exactly 4 cycles after release; cycle 5: all enables=1, stall_cnt_o=0.
- ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5 for one cycle -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, stall_cnt_o +1; ex_rd_i=0 with the same rs2 -> no stall.
- mem_req_i=1, mem_ready_i=0 for 3 cycles, then ready -> 3 cycles with mem_wb_flush_o=1 and upstream enables=0; state MEM_WAIT->RUN; stall_cnt_o +3.
- ex_busy_i and ex_redirect_i together -> busy wins (ex_mem_flush_o=1, pc_en_o=0); busy drops with redirect held -> if_id_flush_o=id_ex_flush_o=1, pc_en_o=1.
- trap_i pulsed 1 cycle during memstall, ready 2 cycles later -> outputs held, then one cycle with all four flushes=1 and trap_take_o=1; RUN.
- MEM_TIMEOUT=4, memstall held 10 cycles -> mem_timeout_o high exactly once, on the 4th wait cycle.
